// File: rtl/asteroids_adc_pkg.sv
// Shared types and constants for the steering-wheel ADC reader.
// WHEEL_SCALE is the downstream multiplier that bounds the wheel clamp.
package asteroids_adc_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CMD      = 2'd1,
      WAIT_RSP = 2'd2,
      FILTER   = 2'd3
   } state_t;

   localparam logic [4:0] WHEEL_CH    = 5'd1;
   localparam int         WHEEL_SCALE = 34;

   function automatic logic [12:0] abs_diff13(input logic [11:0] a, input logic [11:0] b);
      logic [12:0] wa;
      logic [12:0] wb;
      wa = {1'b0, a};
      wb = {1'b0, b};
      return (wa >= wb) ? (wa - wb) : (wb - wa);
   endfunction

endpackage

// File: rtl/wheel_avg_filter.sv
// Box-car average of 2^AVG_LOG2 samples, clamp to WHEEL_MAX and deadband
// hysteresis; publishes wheel with a one-cycle update strobe.
module wheel_avg_filter
   import asteroids_adc_pkg::*;
#(
   parameter int          AVG_LOG2  = 2,
   parameter int          DEADBAND  = 2,
   parameter logic [11:0] WHEEL_MAX = 12'hF0F
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        sample_valid,
   input  logic [11:0] sample_data,
   input  logic        filter_en,
   output logic        last_sample,
   output logic [11:0] wheel,
   output logic        wheel_update
);

   localparam int ACC_W = 12 + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int N     = 1 << AVG_LOG2;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             primed_q, primed_d;
   logic [11:0]      wheel_q, wheel_d;
   logic             upd_q, upd_d;
   logic [11:0]      avg;
   logic [11:0]      clamped;
   logic [12:0]      diff;

   assign last_sample  = (cnt_q == CNT_W'(N - 1));
   assign wheel        = wheel_q;
   assign wheel_update = upd_q;

   always_comb begin
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      primed_d = primed_q;
      wheel_d  = wheel_q;
      upd_d    = 1'b0;
      avg      = 12'(acc_q >> AVG_LOG2);
      clamped  = (avg > WHEEL_MAX) ? WHEEL_MAX : avg;
      diff     = abs_diff13(clamped, wheel_q);
      if (filter_en) begin
         // The first average always loads; the strobe still only fires on a real change.
         if (!primed_q || diff > 13'(DEADBAND)) begin
            wheel_d  = clamped;
            upd_d    = (clamped != wheel_q);
            primed_d = 1'b1;
         end
         acc_d = '0;
         cnt_d = '0;
      end else if (sample_valid) begin
         acc_d = acc_q + ACC_W'(sample_data);
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         primed_q <= 1'b0;
         wheel_q  <= '0;
         upd_q    <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         primed_q <= primed_d;
         wheel_q  <= wheel_d;
         upd_q    <= upd_d;
      end
   end

endmodule

// File: rtl/wheel_adc_reader.sv
// Periodically requests a conversion of the steering potentiometer from the
// MAX10 ADC sequencer (Avalon-ST) and feeds accepted results to the filter.
module wheel_adc_reader
   import asteroids_adc_pkg::*;
#(
   parameter logic [4:0]  CHANNEL    = WHEEL_CH,
   parameter int          SAMPLE_DIV = 50000,
   parameter int          AVG_LOG2   = 2,
   parameter int          DEADBAND   = 2,
   parameter logic [11:0] WHEEL_MAX  = 12'hF0F,
   parameter int          TIMEOUT    = 1023
) (
   input  logic        clk,
   input  logic        resetN,
   output logic        cmd_valid,
   output logic [4:0]  cmd_channel,
   output logic        cmd_startofpacket,
   output logic        cmd_endofpacket,
   input  logic        cmd_ready,
   input  logic        rsp_valid,
   input  logic [4:0]  rsp_channel,
   input  logic [11:0] rsp_data,
   output logic [11:0] wheel,
   output logic        wheel_update,
   output logic        adc_err,
   output state_t      dbg_state
);

   // Command side: cmd_valid holds until cmd_ready; the transfer happens on the
   // cycle both are high and cmd_valid drops the next cycle. Response side has
   // no backpressure: a response counts only in WAIT_RSP with our channel.

   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   state_t          state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic             err_q, err_d;
   logic             tick;
   logic             accept;
   logic             sample_valid;
   logic             filter_en;
   logic             last_sample;

   assign tick              = (div_q == DIV_W'(SAMPLE_DIV - 1));
   assign div_d             = tick ? '0 : div_q + DIV_W'(1);
   assign accept            = rsp_valid && (rsp_channel == CHANNEL);
   assign cmd_channel       = CHANNEL;
   assign cmd_startofpacket = cmd_valid;
   assign cmd_endofpacket   = cmd_valid;
   assign adc_err           = err_q;
   assign dbg_state         = state_q;

   always_comb begin
      state_d      = state_q;
      to_d         = to_q;
      err_d        = err_q;
      sample_valid = 1'b0;
      filter_en    = 1'b0;
      cmd_valid    = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick) state_d = CMD;
         end
         CMD: begin
            cmd_valid = 1'b1;
            if (cmd_ready) begin
               state_d = WAIT_RSP;
               to_d    = '0;
            end
         end
         WAIT_RSP: begin
            if (accept) begin
               sample_valid = 1'b1;
               err_d        = 1'b0;
               state_d      = last_sample ? FILTER : IDLE;
            end else if (to_q == TO_W'(TIMEOUT)) begin
               // Partial sums stay in the filter and resume with later samples.
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         FILTER: begin
            filter_en = 1'b1;
            err_d     = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         div_q   <= '0;
         to_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         to_q    <= to_d;
         err_q   <= err_d;
      end
   end

   wheel_avg_filter #(
      .AVG_LOG2 (AVG_LOG2),
      .DEADBAND (DEADBAND),
      .WHEEL_MAX(WHEEL_MAX)
   ) u_filter (
      .clk         (clk),
      .resetN      (resetN),
      .sample_valid(sample_valid),
      .sample_data (rsp_data),
      .filter_en   (filter_en),
      .last_sample (last_sample),
      .wheel       (wheel),
      .wheel_update(wheel_update)
   );

endmodule

// File: tb/tb_wheel_adc_reader.sv
// Directed bench for wheel_adc_reader: averaging, deadband, clamp, stalled
// command handshake, response timeout, foreign-channel responses and reset.
module tb_wheel_adc_reader;
   import asteroids_adc_pkg::*;

   localparam int SAMPLE_DIV = 32;
   localparam int TIMEOUT    = 100;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        cmd_valid;
   logic [4:0]  cmd_channel;
   logic        cmd_startofpacket;
   logic        cmd_endofpacket;
   logic        cmd_ready = 1'b1;
   logic        rsp_valid = 1'b0;
   logic [4:0]  rsp_channel = 5'd0;
   logic [11:0] rsp_data = 12'd0;
   logic [11:0] wheel;
   logic        wheel_update;
   logic        adc_err;
   state_t      dbg_state;

   int total = 0;
   int bad = 0;
   int upd_cnt = 0;
   int hs_cnt = 0;
   int n_exp = 0;
   logic [11:0] exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   wheel_adc_reader #(
      .CHANNEL   (5'd1),
      .SAMPLE_DIV(SAMPLE_DIV),
      .AVG_LOG2  (2),
      .DEADBAND  (2),
      .WHEEL_MAX (12'hF0F),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk              (clk),
      .resetN           (resetN),
      .cmd_valid        (cmd_valid),
      .cmd_channel      (cmd_channel),
      .cmd_startofpacket(cmd_startofpacket),
      .cmd_endofpacket  (cmd_endofpacket),
      .cmd_ready        (cmd_ready),
      .rsp_valid        (rsp_valid),
      .rsp_channel      (rsp_channel),
      .rsp_data         (rsp_data),
      .wheel            (wheel),
      .wheel_update     (wheel_update),
      .adc_err          (adc_err),
      .dbg_state        (dbg_state)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // scoreboard: every update pulse must match the next expected wheel value
   always @(negedge clk) begin
      if (resetN && wheel_update) begin
         upd_cnt++;
         chk("update_expected", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0) chk("wheel_sb", wheel, exp_q.pop_front());
      end
   end

   always @(posedge clk) begin
      if (resetN && cmd_valid && cmd_ready) hs_cnt++;
   end

   // driver tasks
   task automatic wait_cmd(input logic ready);
      cmd_ready = ready;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cmd_valid) break;
      end
      chk("cmd_wait", cmd_valid, 1);
      chk("cmd_channel", cmd_channel, 5'd1);
      chk("cmd_sop_eop", {cmd_startofpacket, cmd_endofpacket}, 2'b11);
   endtask

   task automatic convert(input logic [11:0] d, input bit bad_first,
                          output logic upd_early, output logic upd, output logic [11:0] w);
      wait_cmd(1'b1);
      @(negedge clk);
      chk("cmd_drop", cmd_valid, 0);
      if (bad_first) begin
         rsp_valid   = 1'b1;
         rsp_channel = 5'd3;
         rsp_data    = 12'hFFF;
         @(negedge clk);
         chk("bad_ch_ignored", dbg_state, WAIT_RSP);
      end
      rsp_valid   = 1'b1;
      rsp_channel = 5'd1;
      rsp_data    = d;
      @(negedge clk);
      rsp_valid   = 1'b0;
      upd_early   = wheel_update;
      @(negedge clk);
      upd = wheel_update;
      w   = wheel;
   endtask

   task automatic group4(input string tag, input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] c, input logic [11:0] d,
                         input logic exp_upd, input logic [11:0] exp_w);
      logic ue, u;
      logic [11:0] w;
      convert(a, 1'b0, ue, u, w);
      convert(b, 1'b0, ue, u, w);
      convert(c, 1'b0, ue, u, w);
      if (exp_upd) begin
         exp_q.push_back(exp_w);
         n_exp++;
      end
      convert(d, 1'b0, ue, u, w);
      chk({tag, "_early"}, ue, 0);
      chk({tag, "_upd"}, u, exp_upd);
      chk({tag, "_wheel"}, w, exp_w);
      @(negedge clk);
      chk({tag, "_pulse_end"}, wheel_update, 0);
   endtask

   initial begin
      int stuck;
      int hs0;
      int waited;
      logic ue, u;
      logic [11:0] w;

      repeat (3) @(negedge clk);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_wheel", wheel, 0);
      chk("rst_update", wheel_update, 0);
      chk("rst_err", adc_err, 0);
      chk("rst_state", dbg_state, IDLE);
      resetN = 1'b1;

      group4("prime", 12'h800, 12'h800, 12'h800, 12'h800, 1'b1, 12'h800);
      group4("hold", 12'h800, 12'h800, 12'h801, 12'h801, 1'b0, 12'h800);
      group4("move", 12'h803, 12'h803, 12'h803, 12'h803, 1'b1, 12'h803);
      group4("deadband_eq", 12'h805, 12'h805, 12'h805, 12'h805, 1'b0, 12'h803);
      group4("clamp", 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 12'hF0F);

      // stalled command, then a response that never comes
      wait_cmd(1'b0);
      chk("stall_state", dbg_state, CMD);
      stuck = 0;
      repeat (200) begin
         @(negedge clk);
         if (!cmd_valid || adc_err) stuck++;
      end
      chk("stall_hold", stuck, 0);
      hs0 = hs_cnt;
      cmd_ready = 1'b1;
      @(negedge clk);
      chk("stall_cmd_drop", cmd_valid, 0);
      waited = 0;
      for (int i = 0; i < TIMEOUT + 50; i++) begin
         @(negedge clk);
         waited++;
         if (adc_err) break;
      end
      chk("timeout_err", adc_err, 1);
      chk("timeout_cycles", waited, TIMEOUT + 1);
      chk("timeout_idle", dbg_state, IDLE);
      chk("one_handshake", hs_cnt - hs0, 1);

      convert(12'h800, 1'b0, ue, u, w);
      chk("err_cleared", adc_err, 0);
      convert(12'h800, 1'b1, ue, u, w);
      chk("bad_ch_no_early_filter", u, 0);
      convert(12'h800, 1'b0, ue, u, w);
      exp_q.push_back(12'h800);
      n_exp++;
      convert(12'h800, 1'b0, ue, u, w);
      chk("resume_upd", u, 1);
      chk("resume_wheel", w, 12'h800);

      // reset in the middle of a conversion
      wait_cmd(1'b1);
      @(negedge clk);
      chk("mid_state", dbg_state, WAIT_RSP);
      resetN = 1'b0;
      #1;
      chk("mid_rst_cmd_valid", cmd_valid, 0);
      chk("mid_rst_wheel", wheel, 0);
      chk("mid_rst_update", wheel_update, 0);
      chk("mid_rst_err", adc_err, 0);
      chk("mid_rst_state", dbg_state, IDLE);
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);

      chk("pulse_count", upd_cnt, n_exp);
      chk("exp_q_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
